// File: rtl/median_filter_stream_pkg.sv
// Shared types and constants for the streaming 3x3 median filter.
// Used by median_filter_stream and med9_pipe.
package median_filter_stream_pkg;

    typedef enum logic [1:0] {
        FILL = 2'd0,
        RUN  = 2'd1,
        TAIL = 2'd2
    } state_t;

    localparam int PIPE_LAT = 3;
    localparam int CNT_W    = 12;

endpackage

// File: rtl/median_filter_stream_med9_pipe.sv
// Three-stage 3x3 median network: row sort, max-of-min/med-of-med/min-of-max,
// then median-of-three. Advances every cycle; win is [row][col].
module med9_pipe #(
    parameter int WIDTH = 8
) (
    input  logic                       CLK,
    input  logic                       CLR,
    input  logic [2:0][2:0][WIDTH-1:0] win,
    output logic [WIDTH-1:0]           med
);

    function automatic logic [WIDTH-1:0] mn(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b);
        return (a < b) ? a : b;
    endfunction

    function automatic logic [WIDTH-1:0] mx(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b);
        return (a < b) ? b : a;
    endfunction

    function automatic logic [WIDTH-1:0] md3(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b,
                                             input logic [WIDTH-1:0] c);
        return mx(mn(a, b), mn(mx(a, b), c));
    endfunction

    logic [2:0][WIDTH-1:0] s1_lo, s1_mi, s1_hi;
    logic [WIDTH-1:0]      s2_a, s2_b, s2_c;

    always_ff @(posedge CLK or posedge CLR) begin
        if (CLR) begin
            s1_lo <= '0;
            s1_mi <= '0;
            s1_hi <= '0;
            s2_a  <= '0;
            s2_b  <= '0;
            s2_c  <= '0;
            med   <= '0;
        end else begin
            for (int r = 0; r < 3; r++) begin
                s1_lo[r] <= mn(mn(win[r][0], win[r][1]), win[r][2]);
                s1_mi[r] <= md3(win[r][0], win[r][1], win[r][2]);
                s1_hi[r] <= mx(mx(win[r][0], win[r][1]), win[r][2]);
            end
            s2_a <= mx(mx(s1_lo[0], s1_lo[1]), s1_lo[2]);
            s2_b <= md3(s1_mi[0], s1_mi[1], s1_mi[2]);
            s2_c <= mn(mn(s1_hi[0], s1_hi[1]), s1_hi[2]);
            med  <= md3(s2_a, s2_b, s2_c);
        end
    end

endmodule

// File: rtl/median_filter_stream.sv
// Streaming 3x3 median filter over a raster image using two line buffers.
// Define MEDIAN_FILTER_BYPASS_EN to add a 'bypass' port that outputs the window centre.
module median_filter_stream
    import median_filter_stream_pkg::*;
#(
    parameter int WIDTH = 8,
    parameter int IMG_W = 640,
    parameter int IMG_H = 480
) (
    input  logic             CLK,
    input  logic             CLR,
    input  logic [WIDTH-1:0] In,
    input  logic             Valid_IN,
`ifdef MEDIAN_FILTER_BYPASS_EN
    input  logic             bypass,
`endif
    output logic [WIDTH-1:0] result,
    output logic             Valid_OUT,
    output logic             Done,
    output logic [15:0]      i
);

    localparam int AW = (IMG_W > 1) ? $clog2(IMG_W) : 1;
    localparam logic [CNT_W-1:0] COL_LAST = CNT_W'(IMG_W - 1);
    localparam logic [CNT_W-1:0] ROW_LAST = CNT_W'(IMG_H - 1);

    state_t                        state, state_nx;
    logic [CNT_W-1:0]              col, row;
    logic [AW-1:0]                 col_a;
    logic [WIDTH-1:0]              lb0 [IMG_W];
    logic [WIDTH-1:0]              lb1 [IMG_W];
    logic [2:0][WIDTH-1:0]         col_new, win_c0, win_c1;
    logic [2:0][2:0][WIDTH-1:0]    win;
    logic                          win_vld, last_px;
    logic [PIPE_LAT-1:0]           vld_pipe, lst_pipe;
    logic [PIPE_LAT-1:0][WIDTH-1:0] ctr_pipe;
    logic [WIDTH-1:0]              med;

    assign col_a   = col[AW-1:0];
    // lb0 holds row r-1, lb1 holds row r-2 at the current column
    assign col_new = {In, lb0[col_a], lb1[col_a]};
    assign win_vld = Valid_IN && (row >= CNT_W'(2)) && (col >= CNT_W'(2));
    assign last_px = Valid_IN && (row == ROW_LAST) && (col == COL_LAST);

    // Newest column is taken live so the accepted pixel enters the sorter this edge
    always_comb begin
        win = '0;
        for (int r = 0; r < 3; r++) begin
            win[r][0] = win_c0[r];
            win[r][1] = win_c1[r];
            win[r][2] = col_new[r];
        end
    end

    always_ff @(posedge CLK) begin
        if (Valid_IN) begin
            lb1[col_a] <= lb0[col_a];
            lb0[col_a] <= In;
        end
    end

    always_comb begin
        state_nx = state;
        case (state)
            FILL: if (Valid_IN && row == CNT_W'(2) && col == CNT_W'(1)) state_nx = RUN;
            RUN:  if (last_px) state_nx = TAIL;
            TAIL: if (Done) state_nx = FILL;
            default: state_nx = FILL;
        endcase
    end

    always_ff @(posedge CLK or posedge CLR) begin
        if (CLR) begin
            state    <= FILL;
            col      <= '0;
            row      <= '0;
            win_c0   <= '0;
            win_c1   <= '0;
            vld_pipe <= '0;
            lst_pipe <= '0;
            ctr_pipe <= '0;
            i        <= '0;
        end else begin
            state    <= state_nx;
            vld_pipe <= {vld_pipe[PIPE_LAT-2:0], win_vld};
            lst_pipe <= {lst_pipe[PIPE_LAT-2:0], last_px};
            ctr_pipe <= {ctr_pipe[PIPE_LAT-2:0], win_c1[1]};
            if (Valid_IN) begin
                win_c0 <= win_c1;
                win_c1 <= col_new;
                if (col == COL_LAST) begin
                    col <= '0;
                    row <= (row == ROW_LAST) ? '0 : row + CNT_W'(1);
                end else begin
                    col <= col + CNT_W'(1);
                end
            end
            // i tracks Valid_OUT of the same cycle; restarts after Done
            if (Done)
                i <= vld_pipe[PIPE_LAT-2] ? 16'd1 : 16'd0;
            else if (vld_pipe[PIPE_LAT-2])
                i <= i + 16'd1;
        end
    end

    med9_pipe #(.WIDTH(WIDTH)) u_med9 (
        .CLK (CLK),
        .CLR (CLR),
        .win (win),
        .med (med)
    );

    assign Valid_OUT = vld_pipe[PIPE_LAT-1];
    assign Done      = vld_pipe[PIPE_LAT-1] & lst_pipe[PIPE_LAT-1];

`ifdef MEDIAN_FILTER_BYPASS_EN
    assign result = bypass ? ctr_pipe[PIPE_LAT-1] : med;
`else
    assign result = med;
`endif

endmodule

// File: tb/tb_median_filter_stream.sv
// Self-checking bench for median_filter_stream (IMG_W=5, IMG_H=4, WIDTH=8).
// A pixel presented in cycle T must produce its result in cycle T+3.
module tb_median_filter_stream;

    localparam int W = 5;
    localparam int H = 4;

    logic       CLK = 1'b0;
    logic       CLR = 1'b0;
    logic [7:0] In = '0;
    logic       Valid_IN = 1'b0;
    logic [7:0] result;
    logic       Valid_OUT, Done;
    logic [15:0] i;
`ifdef MEDIAN_FILTER_BYPASS_EN
    logic       bypass = 1'b0;
`endif

    median_filter_stream #(.WIDTH(8), .IMG_W(W), .IMG_H(H)) dut (
        .CLK       (CLK),
        .CLR       (CLR),
        .In        (In),
        .Valid_IN  (Valid_IN),
`ifdef MEDIAN_FILTER_BYPASS_EN
        .bypass    (bypass),
`endif
        .result    (result),
        .Valid_OUT (Valid_OUT),
        .Done      (Done),
        .i         (i)
    );

    always #5 CLK = ~CLK;

    typedef struct {
        int due;
        int val;
        bit last;
    } exp_t;

    exp_t eq[$];
    int   rec[$];
    int   fr[H][W];
    int   nchk = 0, npass = 0;
    int   ecnt = 0;
    int   mr = 0, mc = 0;
    int   mi = 0;
    bit   mi_clr = 0;
    int   n_res = 0, n_done = 0;
    bit   byp = 0;

    task automatic chk(input string tag, input int got, input int exp);
        nchk++;
        assert (got === exp) npass++;
        else $error("FAIL %s got=%0d exp=%0d", tag, got, exp);
    endtask

    // Reference: median of the 3x3 neighbourhood by sorting nine values
    task automatic model_accept(input int pix);
        int q[$];
        exp_t e;
        fr[mr][mc] = pix;
        if (mr >= 2 && mc >= 2) begin
            for (int dr = -2; dr <= 0; dr++)
                for (int dc = -2; dc <= 0; dc++)
                    q.push_back(fr[mr+dr][mc+dc]);
            q.sort();
            e.due  = ecnt + 2;
            e.val  = byp ? fr[mr-1][mc-1] : q[4];
            e.last = (mr == H-1 && mc == W-1);
            eq.push_back(e);
        end
        mc++;
        if (mc == W) begin
            mc = 0;
            mr = (mr + 1) % H;
        end
    endtask

    task automatic step(input bit v, input int pix);
        exp_t e;
        bit   ev;
        Valid_IN = v;
        In       = 8'(pix);
        @(posedge CLK);
        ecnt++;
        if (v) model_accept(pix);
        #1;
        ev = (eq.size() > 0 && eq[0].due == ecnt);
        if (mi_clr) begin
            mi = 0;
            mi_clr = 0;
        end
        chk("valid_out", int'(Valid_OUT), int'(ev));
        if (ev) begin
            e = eq.pop_front();
            mi = (mi + 1) % 65536;
            chk("result", int'(result), e.val);
            chk("done", int'(Done), int'(e.last));
            if (e.last) mi_clr = 1;
        end else begin
            chk("done_idle", int'(Done), 0);
        end
        chk("i_count", int'(i), mi);
        if (Valid_OUT) begin
            n_res++;
            rec.push_back(int'(result));
        end
        if (Done) n_done++;
    endtask

    task automatic flush(input int n);
        for (int k = 0; k < n; k++) step(1'b0, int'($urandom_range(255, 0)));
    endtask

    task automatic clr_pulse();
        CLR      = 1'b1;
        Valid_IN = 1'b0;
        #1;
        chk("clr_result", int'(result), 0);
        chk("clr_valid", int'(Valid_OUT), 0);
        chk("clr_done", int'(Done), 0);
        chk("clr_i", int'(i), 0);
        @(posedge CLK);
        ecnt++;
        #1;
        CLR = 1'b0;
        eq.delete();
        mr = 0; mc = 0; mi = 0; mi_clr = 0;
    endtask

    initial begin
        int ramp_exp[6];
        ramp_exp = '{6, 7, 8, 11, 12, 13};

        // Power-up reset
        #2;
        clr_pulse();

        // Ramp frame, continuous
        rec.delete(); n_res = 0; n_done = 0;
        for (int p = 0; p < W*H; p++) step(1'b1, p);
        flush(5);
        chk("ramp_count", n_res, 6);
        chk("ramp_done", n_done, 1);
        for (int k = 0; k < 6 && k < rec.size(); k++) chk("ramp_val", rec[k], ramp_exp[k]);

        // Impulse frame: single hot pixel is rejected
        rec.delete(); n_res = 0;
        for (int p = 0; p < W*H; p++) step(1'b1, (p == W + 1) ? 255 : 10);
        flush(5);
        chk("imp_count", n_res, 6);
        for (int k = 0; k < rec.size(); k++) chk("imp_val", rec[k], 10);

        // Ramp with Valid_IN pattern 1,0,0
        rec.delete(); n_res = 0;
        for (int p = 0; p < W*H; p++) begin
            step(1'b1, p);
            step(1'b0, int'($urandom_range(255, 0)));
            step(1'b0, int'($urandom_range(255, 0)));
        end
        flush(3);
        chk("stall_count", n_res, 6);
        for (int k = 0; k < 6 && k < rec.size(); k++) chk("stall_val", rec[k], ramp_exp[k]);

        // Back-to-back ramp frames
        n_res = 0; n_done = 0;
        for (int f = 0; f < 2; f++)
            for (int p = 0; p < W*H; p++) step(1'b1, p);
        flush(5);
        chk("b2b_count", n_res, 12);
        chk("b2b_done", n_done, 2);

        // Random pixels, random gaps, two frames
        for (int f = 0; f < 2; f++) begin
            int p;
            p = 0;
            while (p < W*H) begin
                if ($urandom_range(3, 0) != 0) begin
                    step(1'b1, int'($urandom_range(255, 0)));
                    p++;
                end else begin
                    step(1'b0, int'($urandom_range(255, 0)));
                end
            end
        end
        flush(5);

        // Mid-frame clear while a result is on the output
        for (int p = 0; p < 15; p++) step(1'b1, p);
        chk("pre_clr_valid", int'(Valid_OUT), 1);
        clr_pulse();
        n_res = 0; n_done = 0;
        for (int p = 0; p < W*H; p++) step(1'b1, int'($urandom_range(255, 0)));
        flush(5);
        chk("post_clr_count", n_res, 6);
        chk("post_clr_done", n_done, 1);

`ifdef MEDIAN_FILTER_BYPASS_EN
        // Bypass: centre pixel passes through unfiltered
        bypass = 1'b1;
        byp    = 1'b1;
        rec.delete(); n_res = 0;
        for (int p = 0; p < W*H; p++) step(1'b1, (p == W + 1) ? 255 : 10);
        flush(5);
        chk("byp_count", n_res, 6);
        for (int k = 0; k < rec.size(); k++) chk("byp_val", rec[k], (k == 0) ? 255 : 10);
        bypass = 1'b0;
        byp    = 1'b0;
`endif

        chk("queue_drained", eq.size(), 0);
        $display("%0d/%0d checks passed", npass, nchk);
        $finish;
    end

endmodule
